ysyx_23060020_dmem_resp: RTL
============================

// Module: ysyx_23060020_dmem_resp
// PURPOSE
//  Responder side of the core's data-memory interface: accepts one load/store request at a
//  time over a valid/ready handshake, and accesses an internal word-addressed RAM.
//  Returns read data (or a write acknowledge) after a fixed latency over a response
//  valid/ready handshake that supports backpressure.
//  Serves as the multi-cycle memory model behind the load/store path once the core stops
//  using the single-cycle combinational memory.
// PARAMETERS
//  DEPTH_WORDS  1024           number of 32-bit words in the RAM (power of two)
//  LATENCY      2              cycles from request accept to rsp_valid (legal range 1..15)
//  BASE_ADDR    32'h8000_0000  byte address of word 0
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept request this cycle
//  req_addr     in   32  byte address; bits [1:0] ignored for word select
//  req_wen      in   1   1 = store, 0 = load
//  req_wdata    in   32  store data, lane-aligned
//  req_wmask    in   4   byte-lane write enables (bit i -> wdata[8i+7:8i])
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   requester accepts response
//  rsp_rdata    out  32  full word read (loads); 0 for stores
//  rsp_err      out  1   access fault (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
//    RAM contents are not reset. After rst deasserts, req_ready=1.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE: req_ready=1. Accept happens on any edge with req_valid=1.
//      * The word index is idx=(req_addr-BASE_ADDR)>>2.
//      * A store writes the masked lanes of RAM[idx] at the accept edge.
//      * A load captures RAM[idx] at the accept edge into the response register.
//      * The counter is loaded with LATENCY-1.
//      * Next state is WAIT if LATENCY>1, else RESP.
//  - WAIT: req_ready=0. The counter decrements each cycle; at 1 the next state is RESP.
//  - RESP: req_ready=0, rsp_valid=1.
//      * rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
//      * At that edge the FSM returns to IDLE and rsp_valid drops.
//  - Timing: a request accepted at edge T gives rsp_valid=1 in the cycle after edge T+LATENCY-1,
//    i.e. LATENCY cycles after the accept cycle.
//  - Throughput: at most one outstanding request. With rsp_ready tied 1, back-to-back
//    requests complete one per LATENCY+1 cycles.
//  - Simultaneous events:
//      * A request arriving while in WAIT/RESP is not accepted; the requester must hold it.
//      * A response taken in RESP does not allow same-cycle acceptance (req_ready=0 in RESP).
//  - Store with wmask=4'b0000: no RAM change, normal response.
//  - Store then load to the same word: the load returns the updated data.
//  - rst asserted mid-transaction: the transaction is dropped and outputs take reset values
//    immediately. A store already committed at its accept edge remains in RAM.
//  - Arithmetic: the address subtraction is 32-bit modulo 2^32. idx uses
//    log2(DEPTH_WORDS) bits after range check/wrap.
// CONFIGURATION
//  Macro YSYX_23060020_DMEM_RANGE_CHECK_EN:
//  - Defined:
//      * An address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) is faulted.
//      * The store is suppressed and rsp_rdata=0.
//      * rsp_err=1 with the normal latency and handshake.
//  - Undefined:
//      * idx wraps modulo DEPTH_WORDS (upper bits discarded).
//      * Every access proceeds normally and rsp_err is tied to 0.
// TESTING
//  1. Reset:
//     - Drive rst=1 mid-WAIT, then release.
//     - Require rsp_valid=0, rsp_err=0, rsp_rdata=0 during rst, and req_ready=1 one cycle after release.
//  2. Store/load:
//     - Store 0xDEADBEEF, mask 4'hF to 0x8000_0010, then load 0x8000_0010.
//     - Require rdata=0xDEADBEEF, rsp_valid exactly LATENCY cycles after each accept, rsp_err=0.
//  3. Byte mask:
//     - Write 0x11223344 to 0x8000_0020, then store wdata=0xAABBCCDD, mask 4'b0101.
//     - A load must return 0x11BB33DD.
//  4. Backpressure:
//     - Hold rsp_ready=0 for 5 cycles on a load.
//     - Require rsp_valid and rsp_rdata stable throughout, req_ready=0, and a new req_valid not accepted until after the handshake.
//  5. Range:
//     - Load 0x7FFF_FFFC.
//     - With the macro: rsp_err=1, rdata=0.
//     - Without the macro: data of word (0x7FFF_FFFC-0x8000_0000)>>2 mod DEPTH_WORDS = last word.
//  6. Throughput:
//     - LATENCY=1, rsp_ready=1, 4 back-to-back loads.
//     - Require one response every 2 cycles, in request order.

Source files
------------

// File: rtl/ysyx_23060020_dmem_resp.sv
// rtl/ysyx_23060020_dmem_resp.sv - fixed-latency data-memory responder with valid/ready request and response
// Optional feature macro: YSYX_23060020_DMEM_RANGE_CHECK_EN (fault accesses outside the RAM window)
module ysyx_23060020_dmem_resp #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          fault;
   logic          accept;
   logic          addr_unused;

   // Offset from the window base wraps modulo 2^32, so addresses below BASE_ADDR land high
   assign off    = req_addr - BASE_ADDR;
   assign idx    = off[AW+1:2];
   assign accept = (state == IDLE) && req_valid;

`ifdef YSYX_23060020_DMEM_RANGE_CHECK_EN
   assign fault = (off >= SPAN);
`else
   // Without the check the index simply wraps inside the RAM
   assign fault = 1'b0;
`endif

   // Byte-lane bits and the bits above the index never select a word
   assign addr_unused = ^{off[31:AW+2], off[1:0], SPAN[0]};

   // Store commits the masked lanes at the accept edge; faulted stores are dropped
   always_ff @(posedge clk) begin
      if (!rst && accept && req_wen && !fault) begin
         for (int i = 0; i < 4; i++) begin
            if (req_wmask[i]) begin
               mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Request/response FSM: capture at accept, count down the latency, hold until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  cnt       <= CNT_INIT;
                  rsp_err   <= fault;
                  rsp_rdata <= (req_wen || fault) ? 32'd0 : mem[idx];
                  if (LATENCY > 1) begin
                     state <= WAIT;
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
